// File: rtl/conv_mac_scheduler.sv
// Round-robin scheduler that interleaves up to MAC_LATENCY output pixels through a
// non-stallable pipelined 3x3 MAC, accumulating each pixel over its input channels.

module conv_mac_slot #(
    parameter int AW = 32,
    parameter int CW = 8,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_i,
    input  logic          init_act_i,
    input  logic [PW-1:0] init_pix_i,
    input  logic          sel_i,
    input  logic          ret_i,
    input  logic          issue_i,
    input  logic [CW-1:0] last_ch_i,
    input  logic          refill_ok_i,
    input  logic [PW-1:0] refill_pix_i,
    input  logic [AW-1:0] mac_out_i,
    output logic          want_o,
    output logic          fin_o,
    output logic          act_d_o,
    output logic [PW-1:0] pix_o,
    output logic [PW-1:0] cur_pix_o,
    output logic [CW-1:0] ch_o,
    output logic [AW-1:0] psum_o
);
    logic          act_q, inf_q;
    logic [PW-1:0] pix_q;
    logic [CW-1:0] ch_q;
    logic [AW-1:0] psum_q;
    logic          ret, act_e, inf_e;

    // *_o values are the slot as seen after this cycle's return, so a returning
    // slot can reissue (next channel or freshly assigned pixel) in the same cycle.
    assign ret       = sel_i & ret_i;
    assign fin_o     = ret && (ch_q == last_ch_i);
    assign act_e     = fin_o ? refill_ok_i : act_q;
    assign inf_e     = ret ? 1'b0 : inf_q;
    assign pix_o     = fin_o ? refill_pix_i : pix_q;
    assign ch_o      = fin_o ? '0 : (ret ? ch_q + 1'b1 : ch_q);
    assign psum_o    = ret ? mac_out_i : psum_q;
    assign want_o    = act_e & ~inf_e;
    assign cur_pix_o = pix_q;
    assign act_d_o   = init_i ? init_act_i : (sel_i ? act_e : act_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            inf_q  <= 1'b0;
            pix_q  <= '0;
            ch_q   <= '0;
            psum_q <= '0;
        end else if (init_i) begin
            act_q  <= init_act_i;
            inf_q  <= 1'b0;
            pix_q  <= init_pix_i;
            ch_q   <= '0;
            psum_q <= '0;
        end else if (sel_i) begin
            act_q  <= act_e;
            inf_q  <= inf_e | issue_i;
            pix_q  <= pix_o;
            ch_q   <= ch_o;
            psum_q <= psum_o;
        end
    end
endmodule

module conv_mac_scheduler #(
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int MAC_LATENCY       = 5,
    parameter int CH_WIDTH          = 8,
    parameter int PIX_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         arst_n_in,
    input  logic                         start,
    input  logic [CH_WIDTH-1:0]          num_channels,
    input  logic [PIX_WIDTH-1:0]         num_pixels,
    input  logic [ACCUMULATOR_WIDTH-1:0] bias,
    output logic                         busy,
    output logic                         done,
    input  logic                         op_ready,
    output logic [PIX_WIDTH-1:0]         op_pix,
    output logic [CH_WIDTH-1:0]          op_ch,
    output logic                         mac_input_valid,
    output logic                         mac_hi_group,
    output logic [ACCUMULATOR_WIDTH-1:0] mac_partial_sum,
    input  logic [ACCUMULATOR_WIDTH-1:0] mac_out,
    output logic                         result_valid,
    output logic [PIX_WIDTH-1:0]         result_pix,
    output logic [ACCUMULATOR_WIDTH-1:0] result_data
);
    localparam int AW   = ACCUMULATOR_WIDTH;
    localparam int L    = MAC_LATENCY;
    localparam int PTRW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [PTRW-1:0]      ptr_q, ptr_d;
    logic [L-1:0]         vld_pipe_q;
    logic [CH_WIDTH-1:0]  nch_q;
    logic [PIX_WIDTH-1:0] npix_q;
    logic [AW-1:0]        bias_q;
    logic [PIX_WIDTH:0]   next_pix_q, next_pix_d;
    logic                 hi_q;

    logic running, launch, ret, refill_ok, want, issue, fin;
    logic [L-1:0]                slot_sel, slot_want, slot_fin, slot_act_d;
    logic [L-1:0][PIX_WIDTH-1:0] slot_pix, slot_cur_pix;
    logic [L-1:0][CH_WIDTH-1:0]  slot_ch;
    logic [L-1:0][AW-1:0]        slot_psum;
    logic [PIX_WIDTH-1:0]        pix_mux, cur_pix_mux;
    logic [CH_WIDTH-1:0]         ch_mux;
    logic [AW-1:0]               psum_mux;

    assign running   = (state_q == RUN) || (state_q == DRAIN);
    assign launch    = (state_q == IDLE) && start && (num_channels != '0) && (num_pixels != '0);
    assign ret       = running && vld_pipe_q[L-1];
    assign refill_ok = next_pix_q < {1'b0, npix_q};

    for (genvar s = 0; s < L; s++) begin : g_slot
        assign slot_sel[s] = running && (ptr_q == PTRW'(s));
        conv_mac_slot #(.AW(AW), .CW(CH_WIDTH), .PW(PIX_WIDTH)) u_slot (
            .clk         (clk),
            .rst_n       (arst_n_in),
            .init_i      (launch),
            .init_act_i  ({1'b0, num_pixels} > (PIX_WIDTH+1)'(s)),
            .init_pix_i  (PIX_WIDTH'(s)),
            .sel_i       (slot_sel[s]),
            .ret_i       (ret),
            .issue_i     (issue),
            .last_ch_i   (nch_q - 1'b1),
            .refill_ok_i (refill_ok),
            .refill_pix_i(next_pix_q[PIX_WIDTH-1:0]),
            .mac_out_i   (mac_out),
            .want_o      (slot_want[s]),
            .fin_o       (slot_fin[s]),
            .act_d_o     (slot_act_d[s]),
            .pix_o       (slot_pix[s]),
            .cur_pix_o   (slot_cur_pix[s]),
            .ch_o        (slot_ch[s]),
            .psum_o      (slot_psum[s])
        );
    end

    always_comb begin
        want        = 1'b0;
        fin         = 1'b0;
        pix_mux     = '0;
        cur_pix_mux = '0;
        ch_mux      = '0;
        psum_mux    = '0;
        for (int s = 0; s < L; s++) begin
            if (slot_sel[s]) begin
                want        = slot_want[s];
                fin         = slot_fin[s];
                pix_mux     = slot_pix[s];
                cur_pix_mux = slot_cur_pix[s];
                ch_mux      = slot_ch[s];
                psum_mux    = slot_psum[s];
            end
        end
    end

    // Operand address is presented whenever the slot wants to issue; op_ready only gates the strobe.
    assign issue           = want & op_ready;
    assign mac_input_valid = issue;
    assign op_pix          = want ? pix_mux : '0;
    assign op_ch           = want ? ch_mux : '0;
    assign mac_partial_sum = !want ? '0 : ((ch_mux == '0) ? bias_q : psum_mux);
    assign result_valid    = fin;
    assign result_pix      = fin ? cur_pix_mux : '0;
    assign result_data     = fin ? mac_out : '0;
    assign busy            = running;
    assign done            = (state_q == DONE);
    assign mac_hi_group    = hi_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        next_pix_d = next_pix_q;
        if (launch) begin
            ptr_d      = '0;
            next_pix_d = (PIX_WIDTH+1)'(L);
        end else if (running) begin
            ptr_d = (ptr_q == PTRW'(L-1)) ? '0 : ptr_q + 1'b1;
            if (fin && refill_ok) next_pix_d = next_pix_q + 1'b1;
        end
        case (state_q)
            IDLE:  if (start) state_d = launch ? RUN : DONE;
            RUN: begin
                if (slot_act_d == '0) state_d = DONE;
                else if (next_pix_d >= {1'b0, npix_q}) state_d = DRAIN;
            end
            DRAIN: if (slot_act_d == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            vld_pipe_q <= '0;
            nch_q      <= '0;
            npix_q     <= '0;
            bias_q     <= '0;
            next_pix_q <= '0;
            hi_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            next_pix_q <= next_pix_d;
            vld_pipe_q <= {vld_pipe_q[L-2:0], issue};
            hi_q       <= issue;
            if (launch) begin
                nch_q  <= num_channels;
                npix_q <= num_pixels;
                bias_q <= bias;
            end
        end
    end
endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Bench for conv_mac_scheduler: behavioural 5-deep MAC, vector table, corner sequences
// and randomized jobs checked against per-pixel channel sums.

module tb_conv_mac_scheduler;
    localparam int AW = 32, L = 5, CW = 8, PW = 16;

    logic clk = 1'b0, arst_n_in = 1'b0, start = 1'b0, op_ready = 1'b1;
    logic [CW-1:0] num_channels = '0;
    logic [PW-1:0] num_pixels = '0;
    logic [AW-1:0] bias = '0, mac_out;
    logic busy, done, mac_input_valid, mac_hi_group, result_valid;
    logic [PW-1:0] op_pix, result_pix;
    logic [CW-1:0] op_ch;
    logic [AW-1:0] mac_partial_sum, result_data;

    conv_mac_scheduler #(.ACCUMULATOR_WIDTH(AW), .MAC_LATENCY(L), .CH_WIDTH(CW), .PIX_WIDTH(PW)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .num_channels(num_channels),
        .num_pixels(num_pixels), .bias(bias), .busy(busy), .done(done), .op_ready(op_ready),
        .op_pix(op_pix), .op_ch(op_ch), .mac_input_valid(mac_input_valid),
        .mac_hi_group(mac_hi_group), .mac_partial_sum(mac_partial_sum), .mac_out(mac_out),
        .result_valid(result_valid), .result_pix(result_pix), .result_data(result_data));

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    logic use_tab = 1'b1, rnd_ready = 1'b0;
    logic [31:0] tab [4];
    logic [31:0] tap_seed = 0;

    // Sum of the nine taps for one (pixel, channel) beat.
    function automatic logic [31:0] taps(input logic [PW-1:0] p, input logic [CW-1:0] c);
        if (use_tab) return tab[c[1:0]];
        return ({16'd0, p} + 32'd1) * 32'd2654435761 + {24'd0, c} * 32'd40503 + tap_seed;
    endfunction

    logic [31:0] mpipe [L];
    always @(posedge clk) begin
        mpipe[0] <= mac_partial_sum + taps(op_pix, op_ch);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mac_out = mpipe[L-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    int iq_c[$], iq_p[$], iq_ch[$], rq_c[$], rq_p[$];
    logic [31:0] iq_ps[$], rq_d[$];
    int ech [64];
    logic [31:0] rsum [64];
    bit seen [64];

    task automatic run_job(input int nch, input int npix, input logic [31:0] b,
                           input int bubble, input int again, input int abort, output int done_c);
        int hi_bad, busy_bad, budget, p;
        logic prev_v;
        iq_c.delete(); iq_p.delete(); iq_ch.delete(); iq_ps.delete();
        rq_c.delete(); rq_p.delete(); rq_d.delete();
        for (int k = 0; k < 64; k++) begin ech[k] = 0; rsum[k] = b; seen[k] = 0; end
        hi_bad = 0; busy_bad = 0; prev_v = 1'b0; done_c = -1;
        budget = 40 * nch * npix + 40;
        @(negedge clk);
        num_channels = CW'(nch); num_pixels = PW'(npix); bias = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            op_ready = (c != bubble) && (!rnd_ready || ($urandom_range(0, 3) != 0));
            start = (c == again);
            if (c == abort) begin
                arst_n_in = 1'b0; #1;
                chk("reset_ctl_zero", {59'd0, busy, done, mac_input_valid, mac_hi_group, result_valid}, 0);
                chk("reset_bus_zero", 64'((|op_pix) | (|op_ch) | (|mac_partial_sum) | (|result_pix) | (|result_data)), 0);
                start = 1'b0; op_ready = 1'b1;
                return;
            end
            @(negedge clk);
            if (mac_hi_group !== prev_v) hi_bad++;
            prev_v = mac_input_valid;
            if (busy !== !done) busy_bad++;
            if (mac_input_valid) begin
                p = int'(op_pix);
                iq_c.push_back(c); iq_p.push_back(p); iq_ch.push_back(int'(op_ch)); iq_ps.push_back(mac_partial_sum);
                chk("issue_pix_range", 64'(p < npix), 1);
                if (p < 64) begin
                    chk("issue_ch_order", op_ch, ech[p]);
                    chk("issue_psum", mac_partial_sum, rsum[p]);
                    rsum[p] = rsum[p] + taps(PW'(p), CW'(ech[p]));
                    ech[p]++;
                end
            end
            if (result_valid) begin
                p = int'(result_pix);
                rq_c.push_back(c); rq_p.push_back(p); rq_d.push_back(result_data);
                chk("result_pix_range", 64'(p < npix), 1);
                if (p < 64) begin
                    chk("result_dup", 64'(seen[p]), 0);
                    seen[p] = 1;
                    chk("result_all_ch", ech[p], nch);
                    chk("result_data", result_data, rsum[p]);
                end
            end
            if (done) begin done_c = c; break; end
            @(posedge clk); #1;
        end
        start = 1'b0; op_ready = 1'b1;
        chk("done_seen", 64'(done_c >= 0), 1);
        chk("result_count", rq_c.size(), (nch == 0) ? 0 : npix);
        chk("issue_count", iq_c.size(), nch * npix);
        chk("hi_group_delay", hi_bad, 0);
        chk("busy_vs_done", busy_bad, 0);
    endtask

    typedef struct {
        int nch; int npix; logic [31:0] bias;
        logic [31:0] t0; logic [31:0] t1; logic [31:0] t2;
        int bubble; int again;
        int exp_cnt; int exp_last; logic [31:0] exp_data; int exp_done;
    } vec_t;

    initial begin
        vec_t vt [8];
        int dc, cnt, c5, c6;
        int ea [3];
        logic [31:0] eps [3];

        vt[0] = '{1, 1, 32'd7, 32'd100, 32'd0,  32'd0,  0, 0, 1,  6, 32'd107, 7};
        vt[1] = '{3, 1, 32'd0, 32'd10,  32'd20, 32'd30, 0, 0, 1, 16, 32'd60, 17};
        vt[2] = '{3, 1, 32'd0, 32'd10,  32'd20, 32'd30, 6, 0, 1, 21, 32'd60, 22};
        vt[3] = '{2, 7, 32'd5, 32'd100, 32'd200, 32'd0, 0, 0, 7, 22, 32'd305, 23};
        vt[4] = '{0, 4, 32'd9, 32'd1,   32'd1,  32'd1,  0, 0, 0,  0, 32'd0, 1};
        vt[5] = '{3, 0, 32'd9, 32'd1,   32'd1,  32'd1,  0, 0, 0,  0, 32'd0, 1};
        vt[6] = '{3, 1, 32'd0, 32'd10,  32'd20, 32'd30, 0, 3, 1, 16, 32'd60, 17};
        vt[7] = '{2, 1, 32'hFFFF_FFF0, 32'd16, 32'd5, 32'd0, 0, 0, 1, 11, 32'd5, 12};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("por_ctl_zero", {59'd0, busy, done, mac_input_valid, mac_hi_group, result_valid}, 0);
        chk("por_bus_zero", 64'((|op_pix) | (|op_ch) | (|mac_partial_sum) | (|result_pix) | (|result_data)), 0);
        arst_n_in = 1'b1;

        for (int i = 0; i < 8; i++) begin
            use_tab = 1'b1; rnd_ready = 1'b0;
            tab[0] = vt[i].t0; tab[1] = vt[i].t1; tab[2] = vt[i].t2; tab[3] = 0;
            run_job(vt[i].nch, vt[i].npix, vt[i].bias, vt[i].bubble, vt[i].again, 0, dc);
            chk($sformatf("v%0d_count", i), rq_c.size(), vt[i].exp_cnt);
            chk($sformatf("v%0d_done_cycle", i), dc, vt[i].exp_done);
            chk($sformatf("v%0d_last_result_cycle", i), (rq_c.size() > 0) ? rq_c[$] : 0, vt[i].exp_last);
            if (vt[i].exp_cnt > 0)
                chk($sformatf("v%0d_first_data", i), (rq_d.size() > 0) ? rq_d[0] : 32'hDEAD, vt[i].exp_data);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), 64'(busy | done | mac_input_valid | result_valid), 0);
        end

        // Three-channel lone pixel: issue cadence and fed-back partial sums.
        tab[0] = 10; tab[1] = 20; tab[2] = 30;
        ea[0] = 1; ea[1] = 6; ea[2] = 11; eps[0] = 0; eps[1] = 10; eps[2] = 30;
        run_job(3, 1, 0, 0, 0, 0, dc);
        for (int k = 0; k < 3; k++) begin
            chk("seq3_issue_cycle", (k < iq_c.size()) ? iq_c[k] : -1, ea[k]);
            chk("seq3_issue_psum", (k < iq_ps.size()) ? iq_ps[k] : 32'hDEAD, eps[k]);
        end

        // Same job with a bubble at the first return: reissue slips a full rotation.
        ea[1] = 11; ea[2] = 16;
        run_job(3, 1, 0, 6, 0, 0, dc);
        for (int k = 0; k < 3; k++) begin
            chk("bubble_issue_cycle", (k < iq_c.size()) ? iq_c[k] : -1, ea[k]);
            chk("bubble_issue_psum", (k < iq_ps.size()) ? iq_ps[k] : 32'hDEAD, eps[k]);
        end

        // Slot refill: pixels 5 and 6 take over slots 0 and 1.
        tab[0] = 100; tab[1] = 200;
        run_job(2, 7, 5, 0, 0, 0, dc);
        for (int k = 0; k < rq_c.size(); k++)
            chk("refill_result_cycle", rq_c[k], (rq_p[k] < 5) ? 11 + rq_p[k] : 16 + rq_p[k]);
        c5 = -1; c6 = -1;
        for (int k = 0; k < iq_c.size(); k++) begin
            if (iq_p[k] == 5 && iq_ch[k] == 0) c5 = iq_c[k];
            if (iq_p[k] == 6 && iq_ch[k] == 0) c6 = iq_c[k];
        end
        chk("refill_pix5_issue", c5, 11);
        chk("refill_pix6_issue", c6, 12);

        // Reset in the middle of the 7-pixel job, then a clean restart.
        run_job(2, 7, 5, 0, 0, 8, dc);
        @(negedge clk);
        arst_n_in = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (result_valid | done | busy | mac_input_valid) cnt++;
        end
        chk("quiet_after_reset", cnt, 0);
        tab[0] = 100;
        run_job(1, 1, 7, 0, 0, 0, dc);
        chk("restart_data", (rq_d.size() > 0) ? rq_d[0] : 32'hDEAD, 107);
        chk("restart_cycle", (rq_c.size() > 0) ? rq_c[0] : -1, 6);

        // Randomized jobs with random op_ready stalls.
        use_tab = 1'b0; rnd_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tap_seed = $urandom;
            run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 12)), $urandom, 0, 0, 0, dc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
